// File: rtl/fp_round_pack.sv
// Round-and-pack stage of the 12-bit-to-float converter: extracts a 4-bit significand,
// rounds on the next lower bit and emits {s, e[2:0], f[3:0]} through a 2-stage valid/ready pipe.
module fp_round_pack #(
    parameter int ROUND_EN = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [11:0]      mag,
    input  logic [2:0]       exponent,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       fp_out,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic RND = (ROUND_EN != 0);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [2:0]       s1_exp_q, s1_exp_d;
    logic [3:0]       s1_f_q, s1_f_d;
    logic             s1_r_q, s1_r_d;
    logic             s2_valid_q, s2_valid_d;
    logic [7:0]       s2_fp_q, s2_fp_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic       s1_adv, s2_adv;
    logic       rnd_bit, sat_ev, s2_load;
    logic [3:0] f2;
    logic [2:0] e2;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s2_load  = s2_adv && s1_valid_q;

    // Stage 1: significand is mag[e+3:e], round bit is the one just below it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_f_d     = s1_f_q;
        s1_r_d     = s1_r_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = sign;
                s1_exp_d  = exponent;
                s1_f_d    = mag[exponent +: 4];
                s1_r_d    = (exponent == 3'd0) ? 1'b0 : mag[exponent - 3'd1];
            end
        end
    end

    // Stage 2: round half-up; a full significand carries into the exponent,
    // and at the top exponent the result pins to the largest code instead.
    always_comb begin
        rnd_bit = s1_r_q & RND;
        sat_ev  = 1'b0;
        f2      = s1_f_q;
        e2      = s1_exp_q;
        if (rnd_bit) begin
            if (s1_f_q != 4'hF) begin
                f2 = s1_f_q + 4'd1;
            end else if (s1_exp_q != 3'h7) begin
                f2 = 4'b1000;
                e2 = s1_exp_q + 3'd1;
            end else begin
                f2     = 4'hF;
                e2     = 3'h7;
                sat_ev = 1'b1;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_fp_d    = s2_fp_q;
        sat_cnt_d  = sat_cnt_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_fp_d = {s1_sign_q, e2, f2};
            if (sat_ev && (sat_cnt_q != {CNT_W{1'b1}})) begin
                sat_cnt_d = sat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 3'd0;
            s1_f_q     <= 4'd0;
            s1_r_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_fp_q    <= 8'h00;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_f_q     <= s1_f_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_fp_q    <= s2_fp_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign fp_out    = s2_fp_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: a rounding instance and a truncating instance share
// the same stimulus; outputs are scored against hand-computed expected codes.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sign;
    logic [11:0] mag;
    logic [2:0]  exponent;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [7:0]  fp_out, sat_count;
    logic        t_in_ready, t_out_valid;
    logic [7:0]  t_fp_out, t_sat_count;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_t_q[$];
    logic [7:0] m_e, m_et;

    always #5 clk = ~clk;

    fp_round_pack #(.ROUND_EN(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .mag(mag), .exponent(exponent), .out_valid(out_valid),
        .out_ready(out_ready), .fp_out(fp_out), .sat_count(sat_count)
    );

    fp_round_pack #(.ROUND_EN(0), .CNT_W(8)) u_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .sign(sign), .mag(mag), .exponent(exponent), .out_valid(t_out_valid),
        .out_ready(out_ready), .fp_out(t_fp_out), .sat_count(t_sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic s, input logic [11:0] m, input logic [2:0] e,
                        input logic [7:0] er, input logic [7:0] et);
        int n;
        n = 0;
        sign = s; mag = m; exponent = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(er);
            exp_t_q.push_back(et);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                m_e  = exp_q.pop_front();
                m_et = exp_t_q.pop_front();
                chk("fp_out", 32'(fp_out), 32'(m_e));
                chk("fp_out_trunc", 32'(t_fp_out), 32'(m_et));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sign = 1'b0; mag = 12'h000; exponent = 3'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fp_out", 32'(fp_out), 32'h00);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Reset with two saturating items in flight.
        out_ready = 1'b0;
        send(1'b1, 12'h7FF, 3'd7, 8'hFF, 8'hFF);
        send(1'b1, 12'h7FF, 3'd7, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        chk("pre_rst_sat", 32'(sat_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_fp_out", 32'(fp_out), 32'h00);
        chk("midrst_sat_count", 32'(sat_count), 32'd0);
        exp_q.delete();
        exp_t_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        // Latency: accept at N, visible after N+2.
        send(1'b0, 12'h02C, 3'd2, 8'h2B, 8'h2B);
        in_valid = 1'b0;
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_n2", 32'(out_valid), 32'd1);
        chk("lat_fp", 32'(fp_out), 32'h2B);
        drain();

        // Back-to-back stream.
        send(1'b0, 12'h02E, 3'd2, 8'h2C, 8'h2B);
        send(1'b0, 12'h03E, 3'd2, 8'h38, 8'h2F);
        send(1'b0, 12'h009, 3'd0, 8'h09, 8'h09);
        send(1'b1, 12'h000, 3'd0, 8'h80, 8'h80);
        send(1'b0, 12'h5C0, 3'd7, 8'h7C, 8'h7B);
        send(1'b0, 12'h3E0, 3'd6, 8'h78, 8'h6F);
        send(1'b0, 12'h7FF, 3'd1, 8'h28, 8'h1F);
        in_valid = 1'b0;
        drain();

        // Saturation and counter hold.
        send(1'b1, 12'h7FF, 3'd7, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        drain();
        chk("sat_count_1", 32'(sat_count), 32'd1);
        chk("sat_count_trunc", 32'(t_sat_count), 32'd0);
        for (int i = 0; i < 299; i++) send(1'b1, 12'h7FF, 3'd7, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        drain();
        chk("sat_count_hold", 32'(sat_count), 32'd255);
        chk("sat_count_trunc2", 32'(t_sat_count), 32'd0);

        // Backpressure.
        out_ready = 1'b0;
        send(1'b0, 12'h02C, 3'd2, 8'h2B, 8'h2B);
        send(1'b0, 12'h02E, 3'd2, 8'h2C, 8'h2B);
        sign = 1'b0; mag = 12'h03E; exponent = 3'd2; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_fp_out", 32'(fp_out), 32'h2B);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin
                send(1'b0, 12'h03E, 3'd2, 8'h38, 8'h2F);
                send(1'b0, 12'h009, 3'd0, 8'h09, 8'h09);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("release_rate", 32'(out_valid), 32'd1);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
